// File: rtl/mp_pkg.sv
// Shared types and constants for the microprocessor operand feeder.
package mp_pkg;

   localparam int unsigned DATA_W = 8;

   // Processor state code meaning "waiting for an operand".
   localparam logic [DATA_W-1:0] INPUT_STATE_DEF = 8'h01;

   typedef enum logic [2:0] {
      StIdle,
      StWaitReady,
      StPulse,
      StWaitAck,
      StDone
   } feeder_state_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Operator-input handshake between the feeder (master) and the processor (slave).
interface operand_feeder_if;
   import mp_pkg::*;

   logic [DATA_W-1:0] data_in;
   logic              Enter;
   logic [DATA_W-1:0] CheckState;
   logic              Halt;

   modport master (
      output data_in,
      output Enter,
      input  CheckState,
      input  Halt
   );

   modport slave (
      input  data_in,
      input  Enter,
      output CheckState,
      output Halt
   );

endinterface

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO; one extra pointer bit separates full from empty.
module operand_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok, pop_ok;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level_o = wptr_q - rptr_q;
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      mem_d  = mem_q;
      if (push_ok) begin
         mem_d[wptr_q[AW-1:0]] = wdata_i;
         wptr_d                = wptr_q + 1'b1;
      end
      if (pop_ok) begin
         rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
      mem_q <= mem_d;
   end

endmodule

// File: rtl/operand_feeder.sv
// Feeds buffered operands to the processor with an Enter strobe each time it
// reports the input-wait state, then waits for it to leave that state.
module operand_feeder
   import mp_pkg::*;
#(
   parameter int unsigned       DEPTH        = 4,
   parameter logic [DATA_W-1:0] INPUT_STATE  = INPUT_STATE_DEF,
   parameter int unsigned       ENTER_CYCLES = 1,
   parameter int unsigned       ACK_TIMEOUT  = 64
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 testStart,
   input  logic                 load,
   input  logic [DATA_W-1:0]    load_data,
   operand_feeder_if.master     proc_if,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 overflow,
   output logic [7:0]           sent_count
);

   localparam int unsigned LvlW = $clog2(DEPTH) + 1;
   localparam int unsigned TmoW = $clog2(ACK_TIMEOUT + 1);

   feeder_state_t     state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              enter_q, enter_d;
   logic [3:0]        pcnt_q, pcnt_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [7:0]        sent_q, sent_d;
   logic              err_q, err_d;
   logic              ovf_q, ovf_d;

   logic              pop, full, empty;
   logic [DATA_W-1:0] head;
   logic [LvlW-1:0]   level;
   logic              accept;

   operand_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk_i   (Clock),
      .rst_i   (Reset),
      .push_i  (load),
      .wdata_i (load_data),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign accept = (proc_if.CheckState != INPUT_STATE);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pcnt_d  = pcnt_q;
      tmo_d   = tmo_q;
      sent_d  = sent_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      pop     = 1'b0;

      case (state_q)
         StIdle: begin
            if (testStart) begin
               state_d = empty ? StDone : StWaitReady;
            end
         end
         StWaitReady: begin
            if (proc_if.Halt) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (proc_if.CheckState == INPUT_STATE) begin
               data_d  = head;
               pcnt_d  = '0;
               state_d = StPulse;
            end
         end
         StPulse: begin
            if (proc_if.Halt) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (pcnt_q == 4'(ENTER_CYCLES - 1)) begin
               tmo_d   = '0;
               state_d = StWaitAck;
            end else begin
               pcnt_d = pcnt_q + 4'd1;
            end
         end
         StWaitAck: begin
            if (proc_if.Halt) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (accept) begin
               pop = 1'b1;
               if (sent_q != 8'hFF) begin
                  sent_d = sent_q + 8'd1;
               end
               // A push landing on the pop edge still counts as a remaining entry.
               state_d = ((level > LvlW'(1)) || load) ? StWaitReady : StDone;
            end else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StDone: begin
            if (testStart) begin
               state_d = StIdle;
               sent_d  = '0;
               err_d   = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load && full) begin
         ovf_d = 1'b1;
      end

      enter_d = (state_d == StPulse);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         data_q  <= '0;
         enter_q <= 1'b0;
         pcnt_q  <= '0;
         tmo_q   <= '0;
         sent_q  <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         enter_q <= enter_d;
         pcnt_q  <= pcnt_d;
         tmo_q   <= tmo_d;
         sent_q  <= sent_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign proc_if.data_in = data_q;
   assign proc_if.Enter   = enter_q;
   assign busy            = (state_q != StIdle) && (state_q != StDone);
   assign done            = (state_q == StDone);
   assign error           = err_q;
   assign overflow        = ovf_q;
   assign sent_count      = sent_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder with a small processor model on the default instance.
module tb_operand_feeder;
   import mp_pkg::*;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       testStart;
   logic       load;
   logic [7:0] load_data;
   logic       busy, done, error, overflow;
   logic [7:0] sent_count;
   logic       busy3, done3, error3, overflow3;
   logic [7:0] sent3;

   int n_checks = 0;
   int n_pass   = 0;

   bit         ack_en;
   int         pend, low;
   logic       en_prev;
   logic [7:0] rise_vals[$];

   operand_feeder_if pif ();
   operand_feeder_if pif3 ();

   always #5 Clock = ~Clock;

   operand_feeder dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .testStart  (testStart),
      .load       (load),
      .load_data  (load_data),
      .proc_if    (pif),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .overflow   (overflow),
      .sent_count (sent_count)
   );

   operand_feeder #(.ENTER_CYCLES(3)) dut3 (
      .Clock      (Clock),
      .Reset      (Reset),
      .testStart  (testStart),
      .load       (load),
      .load_data  (load_data),
      .proc_if    (pif3),
      .busy       (busy3),
      .done       (done3),
      .error      (error3),
      .overflow   (overflow3),
      .sent_count (sent3)
   );

   // Processor model: two cycles after Enter drops, show state 02 for two cycles.
   always @(negedge Clock) begin
      if (Reset) begin
         pif.CheckState = 8'h01;
         pend = 0;
         low  = 0;
      end else if (ack_en) begin
         if (pif.Enter) begin
            pend = 2;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               pif.CheckState = 8'h02;
               low = 2;
            end
         end else if (low > 0) begin
            low--;
            if (low == 0) pif.CheckState = 8'h01;
         end
      end
   end

   always @(negedge Clock) begin
      if (pif.Enter === 1'b1 && en_prev !== 1'b1) rise_vals.push_back(pif.data_in);
      en_prev = pif.Enter;
   end

   task automatic apply_reset();
      @(negedge Clock);
      Reset = 1'b1; testStart = 1'b0; load = 1'b0; load_data = '0;
      pif.Halt = 1'b0; pif3.Halt = 1'b0; pif3.CheckState = 8'h01;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] v);
      @(negedge Clock);
      load = 1'b1; load_data = v;
      @(negedge Clock);
      load = 1'b0;
   endtask

   task automatic start();
      @(negedge Clock);
      testStart = 1'b1;
      @(negedge Clock);
      testStart = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge Clock);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (pif.data_in !== 8'h00) $display("FAIL reset_data_in: got %h want 00", pif.data_in); else n_pass++;
      n_checks++; if (pif.Enter !== 1'b0) $display("FAIL reset_enter: got %b want 0", pif.Enter); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
      n_checks++; if (sent_count !== 8'd0) $display("FAIL reset_sent: got %0d want 0", sent_count); else n_pass++;
   endtask

   task automatic test_basic();
      bit ok;
      logic [7:0] v0, v1;
      apply_reset();
      ack_en = 1'b1;
      rise_vals.delete();
      push(8'd10);
      push(8'd20);
      start();
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
      wait_done(300, ok);
      v0 = (rise_vals.size() > 0) ? rise_vals[0] : 8'hFF;
      v1 = (rise_vals.size() > 1) ? rise_vals[1] : 8'hFF;
      n_checks++; if (ok !== 1'b1) $display("FAIL basic_done: got %b want 1", ok); else n_pass++;
      n_checks++; if (rise_vals.size() !== 2) $display("FAIL basic_pulses: got %0d want 2", rise_vals.size()); else n_pass++;
      n_checks++; if (v0 !== 8'd10) $display("FAIL basic_first: got %0d want 10", v0); else n_pass++;
      n_checks++; if (v1 !== 8'd20) $display("FAIL basic_second: got %0d want 20", v1); else n_pass++;
      n_checks++; if (sent_count !== 8'd2) $display("FAIL basic_sent: got %0d want 2", sent_count); else n_pass++;
      n_checks++; if (error !== 1'b0) $display("FAIL basic_error: got %b want 0", error); else n_pass++;
   endtask

   task automatic test_enter_width();
      int hi, runs;
      bit bad, p;
      apply_reset();
      ack_en = 1'b1;
      hi = 0; runs = 0; bad = 1'b0; p = 1'b0;
      push(8'hA5);
      start();
      for (int i = 0; i < 40; i++) begin
         @(negedge Clock);
         if (done3 === 1'b1) break;
         if (pif3.Enter === 1'b1) begin
            hi++;
            if (!p) runs++;
            if (pif3.data_in !== 8'hA5) bad = 1'b1;
         end else if (p) begin
            pif3.CheckState = 8'h02;
         end
         p = (pif3.Enter === 1'b1);
      end
      n_checks++; if (hi !== 3) $display("FAIL width_cycles: got %0d want 3", hi); else n_pass++;
      n_checks++; if (runs !== 1) $display("FAIL width_runs: got %0d want 1", runs); else n_pass++;
      n_checks++; if (bad !== 1'b0) $display("FAIL width_data_stable: got %b want 0", bad); else n_pass++;
      n_checks++; if (done3 !== 1'b1 || sent3 !== 8'd1) $display("FAIL width_done: got done=%b sent=%0d want done=1 sent=1", done3, sent3); else n_pass++;
      pif3.CheckState = 8'h01;
   endtask

   task automatic test_overflow();
      bit ok, saw5;
      apply_reset();
      ack_en = 1'b1;
      rise_vals.delete();
      for (int i = 1; i <= 5; i++) push(8'(i));
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      start();
      wait_done(500, ok);
      saw5 = 1'b0;
      foreach (rise_vals[k]) if (rise_vals[k] === 8'd5) saw5 = 1'b1;
      n_checks++; if (ok !== 1'b1) $display("FAIL ovf_done: got %b want 1", ok); else n_pass++;
      n_checks++; if (rise_vals.size() !== 4) $display("FAIL ovf_pulses: got %0d want 4", rise_vals.size()); else n_pass++;
      n_checks++; if (saw5 !== 1'b0) $display("FAIL ovf_fifth_value: got %b want 0", saw5); else n_pass++;
      n_checks++; if (sent_count !== 8'd4) $display("FAIL ovf_sent: got %0d want 4", sent_count); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
   endtask

   task automatic test_timeout();
      int cyc, rise_at, done_at;
      apply_reset();
      ack_en = 1'b0;
      cyc = 0; rise_at = -1; done_at = -1;
      push(8'd7);
      start();
      for (int i = 0; i < 300; i++) begin
         @(negedge Clock);
         cyc++;
         if (pif.Enter === 1'b1 && rise_at < 0) rise_at = cyc;
         if (done === 1'b1) begin
            done_at = cyc;
            break;
         end
      end
      n_checks++; if (done_at - rise_at !== 65) $display("FAIL tmo_latency: got %0d want 65", done_at - rise_at); else n_pass++;
      n_checks++; if (error !== 1'b1) $display("FAIL tmo_error: got %b want 1", error); else n_pass++;
      n_checks++; if (done !== 1'b1) $display("FAIL tmo_done: got %b want 1", done); else n_pass++;
      n_checks++; if (sent_count !== 8'd0) $display("FAIL tmo_sent: got %0d want 0", sent_count); else n_pass++;
      start();
      n_checks++; if (error !== 1'b0 || done !== 1'b0) $display("FAIL tmo_restart_clear: got err=%b done=%b want 0 0", error, done); else n_pass++;
      ack_en = 1'b1;
   endtask

   task automatic test_halt();
      int r;
      bit p;
      apply_reset();
      ack_en = 1'b1;
      r = 0; p = 1'b0;
      push(8'd11);
      push(8'd22);
      push(8'd33);
      start();
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock);
         if (pif.Enter === 1'b1 && !p) r++;
         p = (pif.Enter === 1'b1);
         if (r == 2) break;
      end
      n_checks++; if (r !== 2) $display("FAIL halt_second_pulse: got %0d rises want 2", r); else n_pass++;
      pif.Halt = 1'b1;
      @(negedge Clock);
      pif.Halt = 1'b0;
      n_checks++; if (done !== 1'b1) $display("FAIL halt_done: got %b want 1", done); else n_pass++;
      n_checks++; if (pif.Enter !== 1'b0) $display("FAIL halt_enter: got %b want 0", pif.Enter); else n_pass++;
      n_checks++; if (error !== 1'b1) $display("FAIL halt_error: got %b want 1", error); else n_pass++;
      n_checks++; if (sent_count !== 8'd1) $display("FAIL halt_sent: got %0d want 1", sent_count); else n_pass++;
      n_checks++; if (pif.data_in !== 8'd22) $display("FAIL halt_data_hold: got %0d want 22", pif.data_in); else n_pass++;
   endtask

   task automatic test_reset_mid_pulse();
      bit seen;
      apply_reset();
      ack_en = 1'b1;
      seen = 1'b0;
      push(8'd44);
      push(8'd55);
      start();
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock);
         if (pif.Enter === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++; if (seen !== 1'b1) $display("FAIL rst_mid_pulse_seen: got %b want 1", seen); else n_pass++;
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      n_checks++; if (pif.Enter !== 1'b0) $display("FAIL rst_mid_enter: got %b want 0", pif.Enter); else n_pass++;
      n_checks++; if (pif.data_in !== 8'h00) $display("FAIL rst_mid_data: got %h want 00", pif.data_in); else n_pass++;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_state: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
      n_checks++; if (sent_count !== 8'd0 || error !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_mid_flags: got sent=%0d err=%b ovf=%b want 0 0 0", sent_count, error, overflow); else n_pass++;
      @(negedge Clock);
      testStart = 1'b1;
      @(negedge Clock);
      testStart = 1'b0;
      @(negedge Clock);
      n_checks++; if (done !== 1'b1) $display("FAIL rst_mid_empty_done: got %b want 1", done); else n_pass++;
      n_checks++; if (sent_count !== 8'd0 || error !== 1'b0) $display("FAIL rst_mid_empty_flags: got sent=%0d err=%b want 0 0", sent_count, error); else n_pass++;
   endtask

   initial begin
      Reset = 1'b1; testStart = 1'b0; load = 1'b0; load_data = '0;
      pif.Halt = 1'b0; pif3.Halt = 1'b0; pif3.CheckState = 8'h01;
      ack_en = 1'b1;
      test_reset();
      test_basic();
      test_enter_width();
      test_overflow();
      test_timeout();
      test_halt();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
